ping_pong_monitor: RTL



---
 rtl/ping_pong_monitor_if.sv | 9 +
 rtl/ping_pong_monitor.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ping_pong_monitor_if.sv
// Sample stream from a ping-pong counter: one advance strobe with value and direction.
interface ping_pong_monitor_if #(parameter int W = 4);
  logic         in_valid;
  logic [W-1:0] in_cnt;
  logic         in_dir;

  modport master (output in_valid, in_cnt, in_dir);
  modport slave  (input  in_valid, in_cnt, in_dir);
endinterface

// File: rtl/ping_pong_monitor.sv
// Receive-side checker for a ping-pong counter stream: locks on, counts bounces/flips, flags faults.
// Optional PPM_FLIP_CNT_EN adds a saturating flip_cnt output.
module ping_pong_monitor #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ping_pong_monitor_if.slave   s,
  input  logic [W-1:0]         max,
  input  logic [W-1:0]         min,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 flip_det,
  output logic [CW-1:0]        bounce_cnt,
  output logic                 err,
  output logic [1:0]           err_code
`ifdef PPM_FLIP_CNT_EN
  ,
  output logic [CW-1:0]        flip_cnt
`endif
);

  typedef enum logic [1:0] {UNLOCKED, LOCKED, FAULT} state_t;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_RANGE = 2'b01;
  localparam logic [1:0] E_STEP  = 2'b10;
  localparam logic [1:0] E_DIR   = 2'b11;

  state_t        state, state_nxt;
  logic [W-1:0]  prev_cnt, prev_cnt_nxt;
  logic          prev_dir, prev_dir_nxt;
  logic          flip_nxt, err_nxt, bounce_inc, bounce_clr;
  logic [1:0]    code_nxt;

  logic [W-1:0]  step;
  logic          cfg_ok, in_range, step_up, step_dn, req_dir, at_bnd, prev_at_bnd;

  assign step        = s.in_cnt - prev_cnt;
  assign cfg_ok      = max > min;
  assign in_range    = (s.in_cnt >= min) && (s.in_cnt <= max);
  assign step_up     = step == W'(1);
  assign step_dn     = step == '1;
  assign at_bnd      = (s.in_cnt == max) || (s.in_cnt == min);
  assign prev_at_bnd = (prev_cnt == max) || (prev_cnt == min);
  // Direction the counter must report after this advance.
  assign req_dir     = (s.in_cnt == max) ? 1'b1 :
                       (s.in_cnt == min) ? 1'b0 : step_dn;

  always_comb begin
    state_nxt    = state;
    prev_cnt_nxt = prev_cnt;
    prev_dir_nxt = prev_dir;
    flip_nxt     = 1'b0;
    err_nxt      = err;
    code_nxt     = err_code;
    bounce_inc   = 1'b0;
    bounce_clr   = 1'b0;
    if (clr_err) begin
      // Clear beats any sample arriving in the same cycle.
      bounce_clr = 1'b1;
      if (state == FAULT) begin
        state_nxt = UNLOCKED;
        err_nxt   = 1'b0;
        code_nxt  = E_NONE;
      end
    end else if (s.in_valid) begin
      unique case (state)
        UNLOCKED: if (cfg_ok && in_range) begin
          state_nxt    = LOCKED;
          prev_cnt_nxt = s.in_cnt;
          prev_dir_nxt = s.in_dir;
        end
        LOCKED: begin
          if (!in_range) begin
            state_nxt = FAULT; err_nxt = 1'b1; code_nxt = E_RANGE;
          end else if (!step_up && !step_dn) begin
            state_nxt = FAULT; err_nxt = 1'b1; code_nxt = E_STEP;
          end else if (s.in_dir != req_dir) begin
            state_nxt = FAULT; err_nxt = 1'b1; code_nxt = E_DIR;
          end else begin
            prev_cnt_nxt = s.in_cnt;
            prev_dir_nxt = s.in_dir;
            bounce_inc   = at_bnd;
            // Reversal away from a boundary is a flip; at a boundary it is a bounce.
            flip_nxt     = (prev_dir ? step_up : step_dn) && !prev_at_bnd;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNLOCKED;
      prev_cnt   <= '0;
      prev_dir   <= 1'b0;
      locked     <= 1'b0;
      flip_det   <= 1'b0;
      bounce_cnt <= '0;
      err        <= 1'b0;
      err_code   <= E_NONE;
`ifdef PPM_FLIP_CNT_EN
      flip_cnt   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      prev_cnt <= prev_cnt_nxt;
      prev_dir <= prev_dir_nxt;
      locked   <= state_nxt == LOCKED;
      flip_det <= flip_nxt;
      err      <= err_nxt;
      err_code <= code_nxt;
      if (bounce_clr)                         bounce_cnt <= '0;
      else if (bounce_inc && bounce_cnt != '1) bounce_cnt <= bounce_cnt + 1'b1;
`ifdef PPM_FLIP_CNT_EN
      if (bounce_clr)                         flip_cnt <= '0;
      else if (flip_nxt && flip_cnt != '1)     flip_cnt <= flip_cnt + 1'b1;
`endif
    end
  end

endmodule
